// File: rtl/led_pkg.sv
// Shared segment encodings for the led_scan display driver.
// Bit order is a..g from MSB to LSB; 1 = segment lit.
package led_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to 7-segment decoder.
// Define LED_SCAN_HEX_EN to show A-F for codes 10-15; otherwise they are blank.
module seg7_decode
    import led_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        // NOTE: default first so every path assigns seg and no latch is inferred.
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
`ifdef LED_SCAN_HEX_EN
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
`endif
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/led_scan.sv
// Time-multiplexed common-cathode 7-segment driver with per-frame snapshot
// and leading-zero blanking. Hex glyphs are enabled by LED_SCAN_HEX_EN.
module led_scan
    import led_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int LZB      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  n_en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    output seg_t                  out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame
);

    localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PCNT_W-1:0]   pcnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] snap_data;
    logic [DIGITS-1:0]   snap_dp;

    logic                tc;
    logic                wrap;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                above_zero;
    logic [DIGITS-1:0]   sel_next;
    seg_t                dec_seg;

    assign tc   = (pcnt == PCNT_W'(SCAN_DIV - 1));
    assign wrap = tc && (idx == IDX_W'(DIGITS - 1));

    // Prescaler, digit index and frame snapshot. The snapshot only loads on
    // the wrap to digit 0, so inputs changing mid-frame never tear.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all registered state.
            pcnt      <= '0;
            idx       <= '0;
            snap_data <= '0;
            snap_dp   <= '0;
            frame     <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (tc) begin
                pcnt <= '0;
                if (wrap) begin
                    idx       <= '0;
                    snap_data <= data;
                    snap_dp   <= dp;
                    frame     <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                pcnt <= pcnt + PCNT_W'(1);
            end
        end
    end

    // Select the active nibble and decide blanking, scanning from the top
    // digit down so above_zero tracks "all higher nibbles are zero".
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        sel_next   = '1;
        above_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above_zero = above_zero && (snap_data[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                cur_nib     = snap_data[4*i +: 4];
                cur_dp      = snap_dp[i];
                sel_next[i] = 1'b0;
                cur_blank   = (LZB != 0) && (i != 0) && above_zero;
            end
        end
    end

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Registered pin drivers; disable blanks the pins but not the scan.
    always_ff @(posedge clk) begin
        if (rst || n_en) begin
            out    <= SEG_BLANK;
            dp_out <= 1'b0;
            sel    <= '1;
        end else begin
            out    <= cur_blank ? SEG_BLANK : dec_seg;
            dp_out <= cur_dp;
            sel    <= sel_next;
        end
    end

endmodule

// File: tb/tb_led_scan.sv
// Self-checking bench for led_scan (DIGITS=4, SCAN_DIV=4) with LZB=1 and LZB=0
// instances side by side; expected frames are queued and popped each cycle.
module tb_led_scan;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       frm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        n_en;
    logic [15:0] data;
    logic [3:0]  dp;

    logic [6:0]  out1, out0;
    logic        dp1, dp0;
    logic [3:0]  sel1, sel0;
    logic        frame1, frame0;

    exp_t        sb1[$];
    exp_t        sb0[$];
    logic [15:0] snap_d;
    logic [3:0]  snap_p;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    led_scan #(.DIGITS(4), .SCAN_DIV(4), .LZB(1)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .n_en   (n_en),
        .data   (data),
        .dp     (dp),
        .out    (out1),
        .dp_out (dp1),
        .sel    (sel1),
        .frame  (frame1)
    );

    led_scan #(.DIGITS(4), .SCAN_DIV(4), .LZB(0)) u_dut_nolzb (
        .clk    (clk),
        .rst    (rst),
        .n_en   (n_en),
        .data   (data),
        .dp     (dp),
        .out    (out0),
        .dp_out (dp0),
        .sel    (sel0),
        .frame  (frame0)
    );

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
`ifdef LED_SCAN_HEX_EN
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            4'hF: return 7'b1000111;
`endif
            default: return 7'b0000000;
        endcase
    endfunction

    // Queue the 16 output cycles that display snapshot d/p. The frame pulse
    // lands on the last cycle of digit 3, one cycle before the next snapshot shows.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] p);
        exp_t       e0, e1;
        logic [3:0] nib;
        logic       hi_zero;
        for (int i = 0; i < 4; i++) begin
            nib     = d[4*i +: 4];
            hi_zero = ((d >> (4*i)) == 16'h0);
            for (int c = 0; c < 4; c++) begin
                e0.sel = 4'b1111 & ~(4'b0001 << i);
                e0.seg = ref_seg(nib);
                e0.dp  = p[i];
                e0.frm = (i == 3 && c == 3);
                e1     = e0;
                if (i > 0 && hi_zero) e1.seg = 7'b0000000;
                sb1.push_back(e1);
                sb0.push_back(e0);
            end
        end
    endtask

    // Advance one clock and compare both DUTs against the queue heads.
    task automatic step(input string tag);
        logic ne;
        exp_t e1, e0, g1, g0;
        ne = n_en;
        @(posedge clk);
        #1;
        if (sb1.size() == 0 || sb0.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, nothing expected", tag);
        end else begin
            e1 = sb1.pop_front();
            e0 = sb0.pop_front();
            if (ne) begin
                e1.sel = 4'hF; e1.seg = 7'h0; e1.dp = 1'b0;
                e0.sel = 4'hF; e0.seg = 7'h0; e0.dp = 1'b0;
            end
            g1 = {sel1, out1, dp1, frame1};
            g0 = {sel0, out0, dp0, frame0};
            n_checks++;
            if (g1 !== e1) begin
                n_fail++;
                $display("FAIL %s lzb1 @%0t: got sel=%b out=%b dp=%b frame=%b, want sel=%b out=%b dp=%b frame=%b",
                         tag, $time, g1.sel, g1.seg, g1.dp, g1.frm, e1.sel, e1.seg, e1.dp, e1.frm);
            end
            n_checks++;
            if (g0 !== e0) begin
                n_fail++;
                $display("FAIL %s lzb0 @%0t: got sel=%b out=%b dp=%b frame=%b, want sel=%b out=%b dp=%b frame=%b",
                         tag, $time, g0.sel, g0.seg, g0.dp, g0.frm, e0.sel, e0.seg, e0.dp, e0.frm);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        n_checks++;
        if ({sel1, out1, dp1, frame1} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s lzb1: got sel=%b out=%b dp=%b frame=%b, want sel=1111 out=0000000 dp=0 frame=0",
                     tag, sel1, out1, dp1, frame1);
        end
        n_checks++;
        if ({sel0, out0, dp0, frame0} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s lzb0: got sel=%b out=%b dp=%b frame=%b, want sel=1111 out=0000000 dp=0 frame=0",
                     tag, sel0, out0, dp0, frame0);
        end
    endtask

    // Run one full frame showing the current snapshot; optionally change the
    // inputs at cycle chg_at and hold n_en for ne_len cycles from ne_from.
    task automatic do_frame(input string tag, input int chg_at, input logic [15:0] nd,
                            input logic [3:0] np, input int ne_from, input int ne_len);
        push_frame(snap_d, snap_p);
        for (int c = 0; c < 16; c++) begin
            if (c == chg_at) begin
                data = nd;
                dp   = np;
            end
            n_en = (c >= ne_from) && (c < ne_from + ne_len);
            step(tag);
        end
        n_en   = 1'b0;
        snap_d = data;
        snap_p = dp;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        n_en = 1'b0;
        data = 16'h1234;
        dp   = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst    = 1'b0;
        snap_d = 16'h0000;
        snap_p = 4'b0000;
    endtask

    task automatic test_first_frame();
        do_frame("first_frame", -1, 16'h0, 4'h0, -1, 0);
        do_frame("second_frame", 0, 16'h0070, 4'b0100, -1, 0);
    endtask

    task automatic test_blanking();
        do_frame("blanking", 0, 16'h1111, 4'b0000, -1, 0);
    endtask

    task automatic test_no_tearing();
        do_frame("no_tearing", 7, 16'h9999, 4'b0000, -1, 0);
    endtask

    task automatic test_enable();
        do_frame("enable", 0, 16'hABCF, 4'b0001, 5, 10);
    endtask

    task automatic test_hex();
        do_frame("hex", 0, 16'h3050, 4'b1010, -1, 0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd;
        for (int k = 0; k < 3; k++) begin
            rd = 16'($urandom_range(0, 65535)) >> (4 * $urandom_range(0, 3));
            do_frame("back_to_back", 3, rd, 4'($urandom_range(0, 15)), -1, 0);
        end
    endtask

    task automatic test_mid_frame_reset();
        push_frame(snap_d, snap_p);
        for (int c = 0; c < 9; c++) step("pre_reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("mid_frame_reset");
        sb1.delete();
        sb0.delete();
        rst    = 1'b0;
        data   = 16'h0808;
        dp     = 4'b0000;
        snap_d = 16'h0000;
        snap_p = 4'b0000;
        do_frame("after_reset", -1, 16'h0, 4'h0, -1, 0);
        do_frame("after_reset_data", -1, 16'h0, 4'h0, -1, 0);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_blanking();
        test_no_tearing();
        test_enable();
        test_hex();
        test_back_to_back();
        test_mid_frame_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
